uart_rx_deser_cfg: RTL and testbench
====================================

Name: uart_rx_deser_cfg

Overview:
Runtime-configurable UART receive deserializer. It converts an oversampled serial line into parallel words of 5..MAX_WORD_WIDTH data bits, with optional even/odd parity and 1 or 2 stop bits. It adds 3-sample majority voting, false-start rejection, parity-error and break detection. It sits between the RX baud tick generator / input synchroniser and the RX FIFO of the UART core.

Parameters:
MAX_WORD_WIDTH, 9, largest supported data word; legal range 5..9.
OVERSAMPLING, 16, i_tick pulses per bit period; must be even and >= 8.

Ports:
i_clk  input  1  clock.
i_rst_n  input  1  reset.
i_tick  input  1  oversampling strobe, single-cycle pulse.
i_din  input  1  serial line, already synchronised to i_clk; idle high.
i_word_len  input  4  data bits per frame, 5..MAX_WORD_WIDTH.
i_parity_en  input  1  1 = a parity bit follows the data bits.
i_parity_odd  input  1  1 = odd parity, 0 = even parity.
i_two_stop  input  1  1 = two stop bits checked.
o_dout  output  MAX_WORD_WIDTH  received word, right-justified, unused upper bits 0.
o_valid  output  1  one-cycle pulse: frame complete; o_dout and flags valid.
o_parity_err  output  1  qualified by o_valid.
o_frame_err  output  1  qualified by o_valid.
o_break  output  1  qualified by o_valid.
o_active  output  1  high whenever state != IDLE.

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock is i_clk. All state is cleared: state = IDLE, counters = 0, o_dout = 0. o_valid, o_parity_err, o_frame_err, o_break and o_active are all 0.
- Reset mid-frame aborts the frame: no o_valid, and the block is in IDLE on the first clock after deassertion.
- Configuration latch: i_word_len, i_parity_en, i_parity_odd and i_two_stop are captured on start detection. Changes during a frame do not affect that frame.
- Out-of-range i_word_len: values < 5 are treated as 5; values > MAX_WORD_WIDTH are treated as MAX_WORD_WIDTH.
- Tick counter: counts 0..OVERSAMPLING-1 on i_tick. It is cleared on start detection and wraps to 0 at each bit boundary.
- Sampling: let M = OVERSAMPLING/2. i_din is sampled on the ticks where the counter equals M-1, M and M+1. The bit value is the 2-of-3 majority, resolved on the M+1 tick.
- State IDLE: when i_din = 0 in any cycle (tick not required) -> START, counter cleared.
- State START: if the majority = 1 -> IDLE (false start); no o_valid, no flags. Otherwise, at counter OVERSAMPLING-1 with i_tick -> DATA.
- State DATA: bits arrive LSB first. Each bit is shifted into the shift register at its majority resolution. After word_len bits -> PARITY if parity is enabled, else STOP1.
- State PARITY: the majority bit is stored. parity_err = XOR(data bits, parity bit, i_parity_odd) != 0. Then -> STOP1 at the bit boundary.
- State STOP1: the majority bit is checked.
  - If two stop bits are configured: -> STOP2 at the bit boundary.
  - Otherwise the frame completes on the M+1 tick. The block does not wait for the bit end, so a back-to-back start bit is caught.
- State STOP2: same check as STOP1; the frame completes on its M+1 tick.
- Completion: registered outputs update, and o_valid pulses for exactly 1 cycle on the clock after the resolving tick.
  - o_frame_err = any checked stop bit read 0.
  - o_dout = data bits only, bits [word_len-1:0]; it holds until the next o_valid.
  - o_parity_err = 0 when parity is disabled.
- Break: o_break = 1 when all data bits, the parity bit (if enabled) and the first stop bit read 0. o_frame_err is then also 1.
  - After a break, the state goes to BRK_WAIT instead of IDLE.
  - BRK_WAIT -> IDLE on the first cycle with i_din = 1. No new start is detected while in BRK_WAIT.
- Next state after completion without break: IDLE. If i_din is already 0 in that IDLE cycle, START begins immediately.
- If i_tick is absent, all counters freeze. Only IDLE start detection and the BRK_WAIT exit run without ticks.
- Latency: o_valid fires (1 + word_len + parity_en + stop_count - 0.5) bit periods + 1 clock after the falling start edge.

Test Plan:
- 8N1, byte 0xA5, OVERSAMPLING=16 -> one o_valid, o_dout=0x0A5, all error flags 0, o_active low after completion.
- 7E2, data 0x41 with a correct even parity bit (0), then a repeat with parity bit 1 -> first frame o_parity_err=0; second o_parity_err=1 with o_dout=0x41.
- 8N1, line low for 4 ticks then high (glitch) -> no o_valid, back in IDLE before the counter reaches M+2; a following valid frame 0x3C is received correctly.
- Single-sample noise: force i_din opposite for only the tick-M sample of each data bit of 0x55 -> o_dout=0x55, no errors.
- 8N1 frame 0x7E with the stop bit driven 0, line then returned high -> o_valid, o_frame_err=1, o_break=0. A line held low for 20 bit periods -> o_break=1, o_frame_err=1, o_dout=0, no further o_valid until the line goes high and a new frame arrives.
- Back-to-back 9O1 frames 0x1FF and 0x000 with no idle gap; i_word_len changed mid-frame -> two o_valid pulses with the correct words, and each frame uses the configuration latched at its own start bit.

Source files
------------

// File: rtl/uart_rx_deser_cfg_if.sv
// Bundle of signals between the UART RX deserialiser and its surroundings.
//   Upstream side (master drives): i_tick oversampling strobe, i_din synchronised serial line,
//   frame configuration i_word_len / i_parity_en / i_parity_odd / i_two_stop.
//   Downstream side (slave drives): o_dout received word, o_valid completion pulse,
//   o_parity_err / o_frame_err / o_break status flags, o_active busy indication.
interface uart_rx_deser_cfg_if #(
  parameter int unsigned MAX_WORD_WIDTH = 9
);
  logic                      i_tick;
  logic                      i_din;
  logic [3:0]                i_word_len;
  logic                      i_parity_en;
  logic                      i_parity_odd;
  logic                      i_two_stop;
  logic [MAX_WORD_WIDTH-1:0] o_dout;
  logic                      o_valid;
  logic                      o_parity_err;
  logic                      o_frame_err;
  logic                      o_break;
  logic                      o_active;

  modport master (
    output i_tick, i_din, i_word_len, i_parity_en, i_parity_odd, i_two_stop,
    input  o_dout, o_valid, o_parity_err, o_frame_err, o_break, o_active
  );

  modport slave (
    input  i_tick, i_din, i_word_len, i_parity_en, i_parity_odd, i_two_stop,
    output o_dout, o_valid, o_parity_err, o_frame_err, o_break, o_active
  );
endinterface

// File: rtl/uart_rx_deser_cfg.sv
// Runtime-configurable UART receive deserialiser with 3-sample majority voting,
// false-start rejection, parity/frame error and break detection.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus_io         : slave side of uart_rx_deser_cfg_if (tick/line/config in, word/flags out)
module uart_rx_deser_cfg #(
  parameter int unsigned MAX_WORD_WIDTH = 9,
  parameter int unsigned OVERSAMPLING   = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  uart_rx_deser_cfg_if.slave  bus_io
);

  localparam int unsigned CntW = $clog2(OVERSAMPLING);
  localparam int unsigned Mid  = OVERSAMPLING / 2;
  localparam logic [CntW-1:0] CntSmp0 = CntW'(Mid - 1);
  localparam logic [CntW-1:0] CntSmp1 = CntW'(Mid);
  localparam logic [CntW-1:0] CntRes  = CntW'(Mid + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLING - 1);
  localparam logic [3:0]      WlMin   = 4'd5;
  localparam logic [3:0]      WlMax   = 4'(MAX_WORD_WIDTH);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop1, StStop2, StBrkWait
  } state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic                      smp0_q, smp0_d, smp1_q, smp1_d;
  logic [MAX_WORD_WIDTH-1:0] shift_q, shift_d;
  logic [3:0]                wl_q, wl_d;
  logic                      par_en_q, par_en_d, par_odd_q, par_odd_d, two_stop_q, two_stop_d;
  logic                      par_err_q, par_err_d, stop_err_q, stop_err_d;
  logic                      all_zero_q, all_zero_d;
  logic [MAX_WORD_WIDTH-1:0] dout_q, dout_d;
  logic                      valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;

  logic       din, tick, at_res, at_end, maj;
  logic       done, done_ferr, done_brk;
  logic [3:0] wl_clamped;

  assign din    = bus_io.i_din;
  assign tick   = bus_io.i_tick;
  assign at_res = tick && (cnt_q == CntRes);
  assign at_end = tick && (cnt_q == CntLast);
  // The third sample is the live line value on the resolving tick.
  assign maj    = (smp0_q & smp1_q) | (smp0_q & din) | (smp1_q & din);

  assign wl_clamped = (bus_io.i_word_len < WlMin) ? WlMin :
                      (bus_io.i_word_len > WlMax) ? WlMax : bus_io.i_word_len;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    smp0_d     = smp0_q;
    smp1_d     = smp1_q;
    shift_d    = shift_q;
    wl_d       = wl_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    all_zero_d = all_zero_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    done       = 1'b0;
    done_ferr  = 1'b0;
    done_brk   = 1'b0;

    // Shared tick counter and sample capture for all in-frame states.
    if (tick) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      if (cnt_q == CntSmp0) smp0_d = din;
      if (cnt_q == CntSmp1) smp1_d = din;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!din) begin
          state_d    = StStart;
          bit_cnt_d  = '0;
          shift_d    = '0;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
          all_zero_d = 1'b1;
          wl_d       = wl_clamped;
          par_en_d   = bus_io.i_parity_en;
          par_odd_d  = bus_io.i_parity_odd;
          two_stop_d = bus_io.i_two_stop;
        end
      end
      StStart: begin
        if (at_res && maj) begin
          state_d = StIdle;
        end else if (at_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (at_res) begin
          shift_d    = shift_q | (MAX_WORD_WIDTH'(maj) << bit_cnt_q);
          bit_cnt_d  = bit_cnt_q + 4'd1;
          all_zero_d = all_zero_q & ~maj;
        end
        if (at_end && (bit_cnt_q == wl_q)) begin
          state_d = par_en_q ? StParity : StStop1;
        end
      end
      StParity: begin
        if (at_res) begin
          par_err_d  = (^shift_q) ^ maj ^ par_odd_q;
          all_zero_d = all_zero_q & ~maj;
        end
        if (at_end) state_d = StStop1;
      end
      StStop1: begin
        if (at_res) begin
          if (two_stop_q) begin
            stop_err_d = ~maj;
            all_zero_d = all_zero_q & ~maj;
          end else begin
            // Finish mid-bit so a back-to-back start edge is not missed.
            done      = 1'b1;
            done_ferr = ~maj;
            done_brk  = all_zero_q & ~maj;
          end
        end
        if (two_stop_q && at_end) state_d = StStop2;
      end
      StStop2: begin
        if (at_res) begin
          done      = 1'b1;
          done_ferr = stop_err_q | ~maj;
          done_brk  = all_zero_q;
        end
      end
      StBrkWait: begin
        cnt_d = '0;
        if (din) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (done) begin
      valid_d = 1'b1;
      dout_d  = shift_q;
      perr_d  = par_en_q & par_err_q;
      ferr_d  = done_ferr;
      brk_d   = done_brk;
      state_d = done_brk ? StBrkWait : StIdle;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      smp0_q     <= 1'b0;
      smp1_q     <= 1'b0;
      shift_q    <= '0;
      wl_q       <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      all_zero_q <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      smp0_q     <= smp0_d;
      smp1_q     <= smp1_d;
      shift_q    <= shift_d;
      wl_q       <= wl_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      all_zero_q <= all_zero_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
    end
  end

  assign bus_io.o_dout       = dout_q;
  assign bus_io.o_valid      = valid_q;
  assign bus_io.o_parity_err = perr_q;
  assign bus_io.o_frame_err  = ferr_q;
  assign bus_io.o_break      = brk_q;
  assign bus_io.o_active     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deser_cfg.sv
// Self-checking bench for uart_rx_deser_cfg: an ideal serial transmitter drives
// tick-aligned frames (directed plus random), a frame-level reference model predicts
// each completed word and its flags, and a monitor compares every o_valid against it.
module tb_uart_rx_deser_cfg;

  localparam int unsigned MaxWw = 9;
  localparam int unsigned Os    = 16;
  localparam int          Mid   = Os / 2;

  typedef struct {
    logic [MaxWw-1:0] dout;
    logic             perr;
    logic             ferr;
    logic             brk;
  } frame_exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  int         n_checks = 0;
  int         n_fail   = 0;
  frame_exp_t exp_q[$];
  frame_exp_t mon_e;

  uart_rx_deser_cfg_if #(.MAX_WORD_WIDTH(MaxWw)) rx_if ();

  uart_rx_deser_cfg #(
    .MAX_WORD_WIDTH(MaxWw),
    .OVERSAMPLING  (Os)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus_io (rx_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int clamp_wl(input int raw);
    if (raw < 5) return 5;
    if (raw > int'(MaxWw)) return int'(MaxWw);
    return raw;
  endfunction

  // Frame-level model: result depends only on the bits that were put on the line.
  function automatic frame_exp_t model(input int wl, input bit pen, input bit pod, input bit two,
                                       input logic [MaxWw-1:0] data, input bit pbit,
                                       input bit s1, input bit s2);
    frame_exp_t e;
    int         ones = 0;
    e.dout = '0;
    for (int i = 0; i < wl; i++) begin
      e.dout[i] = data[i];
      ones += int'(data[i]);
    end
    if (pen) ones += int'(pbit);
    e.perr = pen && ((ones % 2) != (pod ? 1 : 0));
    e.ferr = !s1 || (two && !s2);
    e.brk  = (e.dout == '0) && !(pen && pbit) && !s1;
    return e;
  endfunction

  function automatic int pick_noise(input int mode);
    if (mode != -2) return mode;
    if ($urandom_range(0, 3) == 0) return -1;
    return Mid - 1 + int'($urandom_range(0, 2));
  endfunction

  // One tick period: 1..3 quiet clocks at lvl_gap, then a tick clock at lvl_tick.
  task automatic tick_cycle(input logic lvl_gap, input logic lvl_tick);
    int gap;
    gap = int'($urandom_range(1, 3));
    repeat (gap) begin
      @(negedge clk);
      rx_if.i_din  = lvl_gap;
      rx_if.i_tick = 1'b0;
    end
    @(negedge clk);
    rx_if.i_din  = lvl_tick;
    rx_if.i_tick = 1'b1;
  endtask

  // noise_k >= 0 flips the line only on that tick of the bit.
  task automatic send_bit(input logic lvl, input int noise_k);
    for (int k = 0; k < int'(Os); k++) tick_cycle(lvl, (k == noise_k) ? ~lvl : lvl);
  endtask

  task automatic set_cfg(input int wl_raw, input bit pen, input bit pod, input bit two);
    rx_if.i_word_len   = 4'(wl_raw);
    rx_if.i_parity_en  = pen;
    rx_if.i_parity_odd = pod;
    rx_if.i_two_stop   = two;
  endtask

  task automatic send_frame(input int wl_raw, input bit pen, input bit pod, input bit two,
                            input logic [MaxWw-1:0] data, input bit flip_par,
                            input bit s1, input bit s2, input int noise, input int idle_bits);
    int wl;
    int ones;
    bit pbit;
    wl   = clamp_wl(wl_raw);
    ones = 0;
    for (int i = 0; i < wl; i++) ones += int'(data[i]);
    pbit = bit'(ones % 2) ^ pod ^ flip_par;
    exp_q.push_back(model(wl, pen, pod, two, data, pbit, s1, s2));
    set_cfg(wl_raw, pen, pod, two);
    send_bit(1'b0, pick_noise(noise));
    // Scramble the configuration inputs; the frame in flight must ignore them.
    set_cfg(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < wl; i++) send_bit(data[i], pick_noise(noise));
    if (pen) send_bit(pbit, pick_noise(noise));
    send_bit(s1, pick_noise(noise));
    if (two) send_bit(s2, pick_noise(noise));
    for (int i = 0; i < idle_bits; i++) send_bit(1'b1, -1);
  endtask

  always @(negedge clk) begin
    if (rx_if.o_valid !== 1'b0) begin
      check_eq("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("dout", 32'(rx_if.o_dout), 32'(mon_e.dout));
        check_eq("parity_err", 32'(rx_if.o_parity_err), 32'(mon_e.perr));
        check_eq("frame_err", 32'(rx_if.o_frame_err), 32'(mon_e.ferr));
        check_eq("break", 32'(rx_if.o_break), 32'(mon_e.brk));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  wl_raw;
    bit  pen, pod, two, flip, s1, s2;
    int  idle;
    logic [MaxWw-1:0] data;

    rx_if.i_tick = 1'b0;
    rx_if.i_din  = 1'b1;
    set_cfg(8, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(rx_if.o_valid), 32'd0);
    check_eq("rst_dout", 32'(rx_if.o_dout), 32'd0);
    check_eq("rst_active", 32'(rx_if.o_active), 32'd0);
    check_eq("rst_perr", 32'(rx_if.o_parity_err), 32'd0);
    check_eq("rst_ferr", 32'(rx_if.o_frame_err), 32'd0);
    check_eq("rst_brk", 32'(rx_if.o_break), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 0xA5
    send_frame(8, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1, -1, 1);
    check_eq("a5_active_after", 32'(rx_if.o_active), 32'd0);

    // 7E2 0x41, good then bad parity
    send_frame(7, 1'b1, 1'b0, 1'b1, 9'h041, 1'b0, 1'b1, 1'b1, -1, 1);
    send_frame(7, 1'b1, 1'b0, 1'b1, 9'h041, 1'b1, 1'b1, 1'b1, -1, 1);

    // Glitch: 4 low ticks, then high; must be idle right after the resolving tick
    set_cfg(8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick_cycle(1'b0, 1'b0);
    for (int i = 0; i < Mid + 2 - 4; i++) tick_cycle(1'b1, 1'b1);
    @(negedge clk);
    rx_if.i_tick = 1'b0;
    check_eq("glitch_idle", 32'(rx_if.o_active), 32'd0);
    send_bit(1'b1, -1);
    send_frame(8, 1'b0, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b1, -1, 1);

    // Single-sample noise on the middle sample of every bit
    send_frame(8, 1'b0, 1'b0, 1'b0, 9'h055, 1'b0, 1'b1, 1'b1, Mid, 1);

    // Stop bit low, non-zero data: frame error without break
    send_frame(8, 1'b0, 1'b0, 1'b0, 9'h07E, 1'b0, 1'b0, 1'b1, -1, 2);

    // Line held low for 20 bit periods: one break completion, then wait for high
    begin
      frame_exp_t e;
      e.dout = '0;
      e.perr = 1'b0;
      e.ferr = 1'b1;
      e.brk  = 1'b1;
      exp_q.push_back(e);
    end
    set_cfg(8, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 20; b++) send_bit(1'b0, -1);
    check_eq("brk_active", 32'(rx_if.o_active), 32'd1);
    check_eq("brk_reported", 32'(exp_q.size()), 32'd0);
    send_bit(1'b1, -1);
    send_bit(1'b1, -1);
    check_eq("brk_exit", 32'(rx_if.o_active), 32'd0);

    // Back-to-back 9O1, no idle between frames
    send_frame(9, 1'b1, 1'b1, 1'b0, 9'h1FF, 1'b0, 1'b1, 1'b1, -1, 0);
    send_frame(9, 1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b1, 1'b1, -1, 1);

    // Reset in the middle of a frame aborts it
    set_cfg(8, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    send_bit(1'b0, -1);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_mid_active", 32'(rx_if.o_active), 32'd0);
    @(negedge clk);
    rx_if.i_tick = 1'b0;
    rx_if.i_din  = 1'b1;
    rst_n        = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_idle", 32'(rx_if.o_active), 32'd0);
    send_bit(1'b1, -1);

    // Random frames
    for (int f = 0; f < 30; f++) begin
      wl_raw = int'($urandom_range(0, 15));
      pen    = 1'($urandom);
      pod    = 1'($urandom);
      two    = 1'($urandom);
      data   = MaxWw'($urandom);
      if ($urandom_range(0, 5) == 0) data = '0;
      flip   = ($urandom_range(0, 3) == 0);
      s1     = ($urandom_range(0, 5) != 0);
      s2     = ($urandom_range(0, 5) != 0);
      // A low final stop bit looks like a start edge; give the receiver time to reject it.
      idle   = (two ? !s2 : !s1) ? 2 : int'($urandom_range(0, 1));
      send_frame(wl_raw, pen, pod, two, data, flip, s1, s2, -2, idle);
    end
    send_bit(1'b1, -1);

    repeat (4 * Os) @(negedge clk);
    check_eq("frames_outstanding", 32'(exp_q.size()), 32'd0);
    check_eq("final_active", 32'(rx_if.o_active), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
